// File: rtl/key_db_pkg.sv
// Shared types and default timing constants for the keypad debouncer.
// Defaults assume a 48 MHz system clock.
package key_db_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_48M     = 960000;    // 20 ms
  localparam int HOLD_CYCLES_48M   = 24000000;  // 500 ms
  localparam int REPEAT_CYCLES_48M = 4800000;   // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/db_timer.sv
// Up-counter with synchronous clear and enable; done flags equality with a
// runtime terminal value so one instance can serve several intervals.
module db_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Counter register: clear wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == term);

endmodule

// File: rtl/key_debouncer_rpt.sv
// Keypad debouncer: confirms a stable key code, emits press/release strobes
// and an optional auto-repeat stream while the key stays down.
module key_debouncer_rpt
  import key_db_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int DB_CYCLES     = DB_CYCLES_48M,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_48M,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_48M,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pressed,
  input  logic [WIDTH-1:0] code_in,
  output logic [WIDTH-1:0] code_out,
  output logic             press_pulse,
  output logic             repeat_pulse,
  output logic             release_pulse,
  output logic             held
);

  localparam int CNT_W = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

  db_state_t        state_r, state_nxt_s;
  logic [WIDTH-1:0] cand_r;
  logic             rep_phase_r;

  logic             db_clr_s, db_en_s, db_done_s;
  logic             hold_clr_s, hold_en_s, hold_done_s;
  logic [CNT_W-1:0] hold_term_s;
  logic             cand_ld_s, phase_set_s;
  logic             press_s, repeat_s, release_s, held_s;

  logic [WIDTH-1:0] code_out_r;
  logic             press_r, repeat_r, release_r, held_r;

  assign hold_term_s = rep_phase_r ? REP_TERM : HOLD_TERM;

  db_timer #(.W(CNT_W)) u_db_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (db_clr_s),
    .en    (db_en_s),
    .term  (DB_TERM),
    .done  (db_done_s)
  );

  db_timer #(.W(CNT_W)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr_s),
    .en    (hold_en_s),
    .term  (hold_term_s),
    .done  (hold_done_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_nxt_s = state_r;
    db_clr_s    = 1'b0;
    db_en_s     = 1'b0;
    hold_clr_s  = 1'b0;
    hold_en_s   = 1'b0;
    cand_ld_s   = 1'b0;
    phase_set_s = 1'b0;
    press_s     = 1'b0;
    repeat_s    = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        db_clr_s = 1'b1;
        if (key_pressed) begin
          state_nxt_s = ST_PRESS_DB;
          cand_ld_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESS_DB: begin
        if (!key_pressed) begin
          state_nxt_s = ST_IDLE;
          db_clr_s    = 1'b1;
        end else if (code_in != cand_r) begin
          cand_ld_s = 1'b1;
          db_clr_s  = 1'b1;
        end else if (db_done_s) begin
          state_nxt_s = ST_HELD;
          press_s     = 1'b1;
          db_clr_s    = 1'b1;
          hold_clr_s  = 1'b1;
        end else begin
          db_en_s = 1'b1;
        end
      end
      ST_HELD: begin
        db_clr_s = 1'b1;
        if (!key_pressed) begin
          state_nxt_s = ST_RELEASE_DB;
        end else begin
          hold_en_s = REPEAT_EN;
        end
      end
      ST_RELEASE_DB: begin
        // Returning to HELD counts as a held cycle so the repeat schedule
        // slips by exactly the number of low cycles.
        if (key_pressed) begin
          state_nxt_s = ST_HELD;
          db_clr_s    = 1'b1;
          hold_en_s   = REPEAT_EN;
        end else if (db_done_s) begin
          state_nxt_s = ST_IDLE;
          release_s   = 1'b1;
          db_clr_s    = 1'b1;
        end else begin
          db_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        db_clr_s    = 1'b1;
      end
    endcase

    if (hold_en_s && hold_done_s) begin
      repeat_s    = 1'b1;
      hold_clr_s  = 1'b1;
      phase_set_s = 1'b1;
    end else begin
      repeat_s = 1'b0;
    end

    held_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_RELEASE_DB);
  end

  // Candidate code and repeat-phase tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_r      <= {WIDTH{1'b0}};
      rep_phase_r <= 1'b0;
    end else begin
      if (cand_ld_s) begin
        cand_r <= code_in;
      end else begin
        cand_r <= cand_r;
      end
      if (press_s) begin
        rep_phase_r <= 1'b0;
      end else if (phase_set_s) begin
        rep_phase_r <= 1'b1;
      end else begin
        rep_phase_r <= rep_phase_r;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_out_r <= {WIDTH{1'b1}};
      press_r    <= 1'b0;
      repeat_r   <= 1'b0;
      release_r  <= 1'b0;
      held_r     <= 1'b0;
    end else begin
      if (press_s) begin
        code_out_r <= cand_r;
      end else begin
        code_out_r <= code_out_r;
      end
      press_r   <= press_s;
      repeat_r  <= repeat_s;
      release_r <= release_s;
      held_r    <= held_s;
    end
  end

  assign code_out      = code_out_r;
  assign press_pulse   = press_r;
  assign repeat_pulse  = repeat_r;
  assign release_pulse = release_r;
  assign held          = held_r;

endmodule

// File: tb/tb_key_debouncer_rpt.sv
// Directed bench for key_debouncer_rpt with short intervals (DB=4, HOLD=10,
// REPEAT=3); a second instance has auto-repeat disabled.
module tb_key_debouncer_rpt;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_pressed = 1'b0;
  logic [3:0] code_in = 4'h0;

  logic [3:0] code_out0, code_out1;
  logic       press0, repeat0, release0, held0;
  logic       press1, repeat1, release1, held1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  key_debouncer_rpt #(
    .WIDTH(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .code_in(code_in),
    .code_out(code_out0), .press_pulse(press0), .repeat_pulse(repeat0),
    .release_pulse(release0), .held(held0)
  );

  key_debouncer_rpt #(
    .WIDTH(4), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut_norep (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .code_in(code_in),
    .code_out(code_out1), .press_pulse(press1), .repeat_pulse(repeat1),
    .release_pulse(release1), .held(held1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    key_pressed = 1'b0;
    code_in = 4'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt += 5;
    if (code_out0 !== 4'hF) begin err_cnt++; $display("FAIL reset code_out: got %h expected F", code_out0); end
    if (press0 !== 1'b0) begin err_cnt++; $display("FAIL reset press: got %b expected 0", press0); end
    if (repeat0 !== 1'b0) begin err_cnt++; $display("FAIL reset repeat: got %b expected 0", repeat0); end
    if (release0 !== 1'b0) begin err_cnt++; $display("FAIL reset release: got %b expected 0", release0); end
    if (held0 !== 1'b0) begin err_cnt++; $display("FAIL reset held: got %b expected 0", held0); end
  endtask

  task automatic test_clean_press();
    logic ep, er, erl, eh;
    logic [3:0] ec;
    do_reset();
    code_in = 4'h5;
    for (int k = 0; k <= 40; k++) begin
      key_pressed = (k <= 33);
      tick();
      ep  = (k == 4);
      er  = (k >= 14) && (k <= 33) && (((k - 14) % 3) == 0);
      erl = (k == 38);
      eh  = (k >= 4) && (k < 38);
      ec  = (k >= 4) ? 4'h5 : 4'hF;
      vec_cnt += 5;
      if (press0 !== ep) begin err_cnt++; $display("FAIL clean press edge %0d: got %b expected %b", k, press0, ep); end
      if (repeat0 !== er) begin err_cnt++; $display("FAIL clean repeat edge %0d: got %b expected %b", k, repeat0, er); end
      if (release0 !== erl) begin err_cnt++; $display("FAIL clean release edge %0d: got %b expected %b", k, release0, erl); end
      if (held0 !== eh) begin err_cnt++; $display("FAIL clean held edge %0d: got %b expected %b", k, held0, eh); end
      if (code_out0 !== ec) begin err_cnt++; $display("FAIL clean code_out edge %0d: got %h expected %h", k, code_out0, ec); end
    end
  endtask

  task automatic test_press_bounce();
    logic ep, eh;
    int presses;
    presses = 0;
    do_reset();
    code_in = 4'h5;
    for (int k = 0; k <= 12; k++) begin
      key_pressed = (k != 1);
      tick();
      ep = (k == 6);
      eh = (k >= 6);
      if (press0 === 1'b1) presses++;
      vec_cnt += 2;
      if (press0 !== ep) begin err_cnt++; $display("FAIL bounce press edge %0d: got %b expected %b", k, press0, ep); end
      if (held0 !== eh) begin err_cnt++; $display("FAIL bounce held edge %0d: got %b expected %b", k, held0, eh); end
    end
    vec_cnt++;
    if (presses != 1) begin err_cnt++; $display("FAIL bounce press count: got %0d expected 1", presses); end
  endtask

  task automatic test_code_change();
    logic ep;
    logic [3:0] ec;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      key_pressed = 1'b1;
      code_in = (k >= 2) ? 4'h9 : 4'h5;
      tick();
      ep = (k == 6);
      ec = (k >= 6) ? 4'h9 : 4'hF;
      vec_cnt += 2;
      if (press0 !== ep) begin err_cnt++; $display("FAIL codechg press edge %0d: got %b expected %b", k, press0, ep); end
      if (code_out0 !== ec) begin err_cnt++; $display("FAIL codechg code_out edge %0d: got %h expected %h", k, code_out0, ec); end
    end
  endtask

  task automatic test_release_glitch();
    logic er, eh;
    do_reset();
    code_in = 4'h5;
    for (int k = 0; k <= 24; k++) begin
      key_pressed = !((k == 8) || (k == 9));
      tick();
      er = (k == 16) || (k == 19) || (k == 22);
      eh = (k >= 4);
      vec_cnt += 3;
      if (repeat0 !== er) begin err_cnt++; $display("FAIL glitch repeat edge %0d: got %b expected %b", k, repeat0, er); end
      if (held0 !== eh) begin err_cnt++; $display("FAIL glitch held edge %0d: got %b expected %b", k, held0, eh); end
      if (release0 !== 1'b0) begin err_cnt++; $display("FAIL glitch release edge %0d: got %b expected 0", k, release0); end
    end
  endtask

  task automatic test_no_repeat();
    logic ep, eh;
    do_reset();
    code_in = 4'h3;
    for (int k = 0; k <= 54; k++) begin
      key_pressed = 1'b1;
      tick();
      ep = (k == 4);
      eh = (k >= 4);
      vec_cnt += 3;
      if (repeat1 !== 1'b0) begin err_cnt++; $display("FAIL norep repeat edge %0d: got %b expected 0", k, repeat1); end
      if (press1 !== ep) begin err_cnt++; $display("FAIL norep press edge %0d: got %b expected %b", k, press1, ep); end
      if (held1 !== eh) begin err_cnt++; $display("FAIL norep held edge %0d: got %b expected %b", k, held1, eh); end
    end
  endtask

  task automatic test_reset_in_held();
    do_reset();
    code_in = 4'h5;
    key_pressed = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
    end
    vec_cnt++;
    if (held0 !== 1'b1) begin err_cnt++; $display("FAIL midreset pre held: got %b expected 1", held0); end
    #2;
    reset = 1'b0;
    #1;
    vec_cnt += 5;
    if (code_out0 !== 4'hF) begin err_cnt++; $display("FAIL midreset code_out: got %h expected F", code_out0); end
    if (press0 !== 1'b0) begin err_cnt++; $display("FAIL midreset press: got %b expected 0", press0); end
    if (repeat0 !== 1'b0) begin err_cnt++; $display("FAIL midreset repeat: got %b expected 0", repeat0); end
    if (release0 !== 1'b0) begin err_cnt++; $display("FAIL midreset release: got %b expected 0", release0); end
    if (held0 !== 1'b0) begin err_cnt++; $display("FAIL midreset held: got %b expected 0", held0); end
    tick();
    key_pressed = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vec_cnt += 2;
      if (release0 !== 1'b0) begin err_cnt++; $display("FAIL midreset release after edge %0d: got %b expected 0", k, release0); end
      if (held0 !== 1'b0) begin err_cnt++; $display("FAIL midreset held after edge %0d: got %b expected 0", k, held0); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_code_change();
    test_release_glitch();
    test_no_repeat();
    test_reset_in_held();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
